// File: rtl/oit_keypad_encoder.sv
// ---------------------------------------------------------------------------
// oit_keypad_encoder
//   Scans a 4x4 matrix keypad one column at a time, debounces the row sense,
//   and delivers the hex code of a single pressed key over a valid/ready
//   handshake with a one-deep output buffer.
//
// Ports
//   clock      in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-high
//   col        out  4  column drive, exactly one bit at ACTIVE
//   row        in   4  raw row sense, asynchronous to clock
//   key        out  4  encoded key code, stable while key_valid is high
//   key_valid  out  1  a new code is available
//   key_ready  in   1  consumer accepts the code
//   pressed    out  1  high while a debounced key is held
//   overrun    out  1  an unconsumed code was overwritten
// ---------------------------------------------------------------------------
module oit_keypad_encoder #(
  parameter int          SCAN_DIV = 4,
  parameter int          DEBOUNCE = 3,
  parameter logic        ACTIVE   = 1'b0,
  parameter logic [63:0] KEYMAP   = 64'hFEDCBA9876543210
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       pressed,
  output logic       overrun
);

  localparam int DCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DCW-1:0] DC_LAST  = DCW'(SCAN_DIV - 1);
  // cnt_r == CNT_LAST means the current matching sample is the DEBOUNCE-th.
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [3:0]     IDLE_LVL = {4{~ACTIVE}};

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // Column drive pattern with only column idx at the asserted level.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] v;
    v      = IDLE_LVL;
    v[idx] = ACTIVE;
    return v;
  endfunction

  logic [3:0]     sync1_r;
  logic [3:0]     rs_r;
  logic [DCW-1:0] dc_r;
  logic [1:0]     ci_r;
  logic [CW-1:0]  cnt_r;
  logic [1:0]     r_r;
  state_t         state_r;
  logic [3:0]     col_r;
  logic           pressed_r;
  logic [3:0]     key_r;
  logic           key_valid_r;
  logic           overrun_r;

  logic [3:0]     row_hit_s;
  logic           sample_s;
  logic           single_s;
  logic [1:0]     row_idx_s;
  logic           none_s;
  logic           same_row_s;
  logic           accept_s;
  logic [5:0]     key_bit_s;
  logic [3:0]     code_s;

  // Two-flop synchronizer for the asynchronous row sense.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= IDLE_LVL;
      rs_r    <= IDLE_LVL;
    end else begin
      sync1_r <= row;
      rs_r    <= sync1_r;
    end
  end

  assign row_hit_s = ACTIVE ? rs_r : ~rs_r;
  assign sample_s  = (dc_r == DC_LAST);

  // Row decode: single-row detection, match against the captured row, accept strobe.
  always_comb begin
    single_s  = 1'b0;
    row_idx_s = 2'd0;
    case (row_hit_s)
      4'b0001: begin single_s = 1'b1; row_idx_s = 2'd0; end
      4'b0010: begin single_s = 1'b1; row_idx_s = 2'd1; end
      4'b0100: begin single_s = 1'b1; row_idx_s = 2'd2; end
      4'b1000: begin single_s = 1'b1; row_idx_s = 2'd3; end
      default: begin single_s = 1'b0; row_idx_s = 2'd0; end
    endcase
    none_s     = (row_hit_s == 4'b0000);
    same_row_s = single_s && (row_idx_s == r_r);
    accept_s   = 1'b0;
    if (sample_s) begin
      case (state_r)
        ST_SCAN:     accept_s = single_s && (DEBOUNCE == 1);
        ST_DEBOUNCE: accept_s = same_row_s && (cnt_r == CNT_LAST);
        default:     accept_s = 1'b0;
      endcase
    end else begin
      accept_s = 1'b0;
    end
    // ci_r is held from detection to accept, so it is the key's column.
    key_bit_s = {row_idx_s, ci_r, 2'b00};
    code_s    = KEYMAP[key_bit_s +: 4];
  end

  // Scan/debounce FSM with dwell counter, column index and registered col/pressed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_SCAN;
      dc_r      <= '0;
      ci_r      <= 2'd0;
      cnt_r     <= '0;
      r_r       <= 2'd0;
      col_r     <= col_drive(2'd0);
      pressed_r <= 1'b0;
    end else begin
      dc_r <= sample_s ? '0 : dc_r + {{(DCW-1){1'b0}}, 1'b1};
      if (sample_s) begin
        case (state_r)
          ST_SCAN: begin
            if (single_s) begin
              r_r <= row_idx_s;
              if (DEBOUNCE == 1) begin
                state_r   <= ST_HELD;
                cnt_r     <= '0;
                pressed_r <= 1'b1;
              end else begin
                state_r <= ST_DEBOUNCE;
                cnt_r   <= CW'(1);
              end
            end else begin
              ci_r  <= ci_r + 2'd1;
              col_r <= col_drive(ci_r + 2'd1);
            end
          end
          ST_DEBOUNCE: begin
            if (same_row_s) begin
              if (cnt_r == CNT_LAST) begin
                state_r   <= ST_HELD;
                cnt_r     <= '0;
                pressed_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
              end
            end else begin
              state_r <= ST_SCAN;
              cnt_r   <= '0;
              ci_r    <= ci_r + 2'd1;
              col_r   <= col_drive(ci_r + 2'd1);
            end
          end
          ST_HELD: begin
            if (none_s) begin
              if (cnt_r == CNT_LAST) begin
                state_r   <= ST_SCAN;
                cnt_r     <= '0;
                pressed_r <= 1'b0;
                ci_r      <= ci_r + 2'd1;
                col_r     <= col_drive(ci_r + 2'd1);
              end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
              end
            end else begin
              // Any row activity restarts the release count.
              cnt_r <= '0;
            end
          end
          default: begin
            state_r   <= ST_SCAN;
            cnt_r     <= '0;
            pressed_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  // One-deep output buffer with valid/ready handshake and overrun flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_r       <= 4'd0;
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (accept_s) begin
      key_r       <= code_s;
      key_valid_r <= 1'b1;
      // Old code lost only if nobody takes it on this edge.
      if (key_valid_r && !key_ready) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end else if (key_valid_r && key_ready) begin
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      key_valid_r <= key_valid_r;
    end
  end

  assign col       = col_r;
  assign key       = key_r;
  assign key_valid = key_valid_r;
  assign pressed   = pressed_r;
  assign overrun   = overrun_r;

endmodule

// File: doc/oit_keypad_encoder.md
# oit_keypad_encoder

Scans a 4x4 matrix keypad, debounces it, and encodes the pressed key as a 4-bit hex code. It is the input-side counterpart of the hex-to-7-segment decoder: this block turns switch closures into hex values, and the decoder turns hex values into segment patterns. It sits between board keypad pins and the user-logic consumer. Key codes are delivered over a valid/ready handshake with a one-deep output buffer and an overrun flag.

## Interface
- SCAN_DIV, 4: clock cycles each column is driven. The minimum legal value is 4.
- DEBOUNCE, 3: consecutive matching samples needed to accept a press, and consecutive clear samples needed to accept a release. The minimum is 1.
- ACTIVE, 0: asserted level of both the column drive and the row sense. 0 gives active-low with row pull-ups.
- KEYMAP, 64'hFEDCBA9876543210: code table. A key at row r, column c maps to index i = r*4+c, and its code is KEYMAP[i*4+3:i*4].

Ports:
- clock  in  1  system clock. All logic is rising-edge.
- reset  in  1  asynchronous, active-high.
- col  out  4  column drive. Exactly one bit is at ACTIVE; the others are at ~ACTIVE.
- row  in  4  raw row sense from the pins. Asynchronous to clock.
- key  out  4  encoded key code. Stable while key_valid is high.
- key_valid  out  1  a new code is available.
- key_ready  in  1  consumer accepts the code.
- pressed  out  1  high while a debounced key is held.
- overrun  out  1  an unconsumed code was overwritten.

## Operation
- row passes through a 2-flop synchronizer, giving rs. Row j is asserted when rs[j]==ACTIVE.
- Dwell counter dc runs from 0 to SCAN_DIV-1 and wraps. Sample point: dc==SCAN_DIV-1.
- Column index ci: 0..3. It advances only at a sample point in SCAN (or when leaving DEBOUNCE/HELD to SCAN), wraps 3->0, and is otherwise held.
- Single-row rule: a sample is a press only if exactly one row is asserted. Zero rows, or two or more rows asserted, counts as no press.
- States: SCAN, DEBOUNCE, HELD. At each sample point:
  - SCAN: if the single-row rule holds, capture r=row and c=ci, set cnt=1, and hold ci. If DEBOUNCE==1, go directly to HELD and accept the key. Otherwise go to DEBOUNCE. If the rule fails, advance ci.
  - DEBOUNCE: if the same single row is asserted, cnt++. When cnt reaches DEBOUNCE, accept the key and go to HELD with cnt=0. On any mismatch, go to SCAN and advance ci.
  - HELD: if no rows are asserted, cnt++; otherwise cnt=0. When cnt reaches DEBOUNCE, go to SCAN and advance ci.
- Accept: key <= KEYMAP code for (r,c), and key_valid <= 1. If key_valid was already 1 and key_ready is 0 in that cycle, overrun <= 1 (the old code is lost).
- Handshake: a transfer happens on a clock edge where key_valid && key_ready. key_valid then drops, unless an accept occurs in the same cycle. In that case key_valid stays 1 with the new code and overrun is unchanged. overrun clears on any transfer.
- pressed = (state==HELD).
- Reset values: state=SCAN, ci=0, dc=0, cnt=0, synchronizer=~ACTIVE, key=0, key_valid=0, pressed=0, overrun=0.
- col after reset: col[0]=ACTIVE, all others ~ACTIVE.
- Reset mid-operation: all captured state is discarded. A key still held after reset is detected and reported again.

## Timing
- col changes on the edge after the sample point that advances ci.
- The sample is taken ≥3 cycles after a column change, which requires SCAN_DIV≥4. This covers the 2-cycle synchronizer delay.
- A full keypad scan with no key takes 4*SCAN_DIV cycles.
- Press latency: key_valid rises on the edge after the DEBOUNCE-th matching sample. That is (DEBOUNCE-1)*SCAN_DIV cycles after the first detecting sample, plus 1.
- Release latency: pressed falls on the edge after the DEBOUNCE-th clear sample.
- key and key_valid are registered outputs with no combinational path from key_ready. pressed and col are also registered.
- Bounce shorter than DEBOUNCE samples never yields key_valid.

## Test plan
- Idle, with all rows at ~ACTIVE: col steps 0→1→2→3→0, each column held exactly SCAN_DIV=4 cycles. key_valid, pressed and overrun stay 0.
- Clean press at row 2, col 1, with key_ready=1: key=4'h9 and key_valid high for exactly 1 cycle. pressed stays high until release, then falls after 3 clear samples. No second code is produced while the key is held.
- Bounce: row toggles every sample for 5 samples, then settles. Exactly one key_valid results, and it occurs 3 stable samples after settling.
- Two rows asserted in the same column: no key_valid and scanning continues. Releasing one row gives a valid code for the remaining row.
- Backpressure with key_ready=0: press 4'h3, release, then press 4'hC. key=4'hC and overrun=1. Setting key_ready=1 for one cycle clears both key_valid and overrun.
- Reset asserted while in HELD on key 4'h5 (key held): all outputs return to reset values immediately. After reset is released, 4'h5 is reported again.
